// File: rtl/regfile_rename_pkg.sv
// ============================================================================
// Module  : regfile_rename_pkg
// Brief   : Shared widths and types for the renaming register file.
//           Holds the constants that live alongside the ROB definitions.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_rename_pkg;

  // Register index, datapath and ROB tag widths
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;
  localparam int REG_SIZE   = 32;

  // Tag meaning "no producer"; ROB entries start at 1, so 0 is never live
  localparam logic [ROB_WIDTH-1:0] ZERO_REORDER_TAG = '0;

  // Result of one operand query
  typedef struct packed {
    logic                  busy;
    logic [ROB_WIDTH-1:0]  reorder;
    logic [DATA_WIDTH-1:0] value;
  } query_t;

endpackage : regfile_rename_pkg

`default_nettype wire

// File: rtl/regfile_rename.sv
// ============================================================================
// Module  : regfile_rename
// Brief   : Architectural integer register file with per-register busy bit
//           and ROB reorder tag. Written by ROB commit, renamed by decoder,
//           queried combinationally for two source operands. Flush clears
//           all rename state.
// Config  : REGFILE_BYPASS_EN - forward a same-cycle commit to the queries
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int                   REG_COUNT    = REG_SIZE,
  parameter logic [ROB_WIDTH-1:0] ZERO_REORDER = ZERO_REORDER_TAG
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_rdy,
  input  logic                  in_flush_enable,
  input  logic                  in_decoder_rename_enable,
  input  logic [REG_WIDTH-1:0]  in_decoder_rename_rd,
  input  logic [ROB_WIDTH-1:0]  in_decoder_rename_reorder,
  input  logic [REG_WIDTH-1:0]  in_decoder_rs,
  input  logic [REG_WIDTH-1:0]  in_decoder_rt,
  output logic                  out_decoder_rs_busy,
  output logic                  out_decoder_rt_busy,
  output logic [ROB_WIDTH-1:0]  out_decoder_rs_reorder,
  output logic [ROB_WIDTH-1:0]  out_decoder_rt_reorder,
  output logic [DATA_WIDTH-1:0] out_decoder_rs_value,
  output logic [DATA_WIDTH-1:0] out_decoder_rt_value,
  input  logic                  in_rob_commit_enable,
  input  logic [REG_WIDTH-1:0]  in_rob_commit_rd,
  input  logic [DATA_WIDTH-1:0] in_rob_commit_value,
  input  logic [ROB_WIDTH-1:0]  in_rob_commit_reorder
);

  // Per-register architectural state
  logic [DATA_WIDTH-1:0] r_value   [REG_COUNT];
  logic                  r_busy    [REG_COUNT];
  logic [ROB_WIDTH-1:0]  r_reorder [REG_COUNT];

  // Qualified strobes; x0 writes/renames are dropped here
  logic   w_commit_valid;
  logic   w_rename_valid;
  logic   w_flush_valid;
  query_t w_rs_q;
  query_t w_rt_q;

  assign w_commit_valid = in_rdy && in_rob_commit_enable && (in_rob_commit_rd != '0);
  assign w_flush_valid  = in_rdy && in_flush_enable;
  assign w_rename_valid = in_rdy && in_decoder_rename_enable && !in_flush_enable &&
                          (in_decoder_rename_rd != '0);

  // Operand query: registered state, x0 forced to zero, optional commit bypass
  function automatic query_t f_query(input logic [REG_WIDTH-1:0] idx);
    query_t q;
    q.busy    = r_busy[idx];
    q.reorder = r_reorder[idx];
    q.value   = r_value[idx];
`ifdef REGFILE_BYPASS_EN
    // A same-cycle commit is forwarded; a same-cycle rename is not visible yet
    if (w_commit_valid && (in_rob_commit_rd == idx)) begin
      q.value = in_rob_commit_value;
      if (r_reorder[idx] == in_rob_commit_reorder) begin
        q.busy    = 1'b0;
        q.reorder = ZERO_REORDER;
      end
    end
`endif
    if (idx == '0) begin
      q.busy    = 1'b0;
      q.reorder = ZERO_REORDER;
      q.value   = '0;
    end
    return q;
  endfunction

  // Committed values: written on every valid commit, including in a flush cycle
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_value[i] <= '0;
      end
    end else if (w_commit_valid) begin
      r_value[in_rob_commit_rd] <= in_rob_commit_value;
    end
  end

  // Rename state: commit retires matching producer, flush clears all,
  // rename (later assignment) overrides a same-register commit
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_busy[i]    <= 1'b0;
        r_reorder[i] <= ZERO_REORDER;
      end
    end else begin
      if (w_commit_valid && (r_reorder[in_rob_commit_rd] == in_rob_commit_reorder)) begin
        r_busy[in_rob_commit_rd]    <= 1'b0;
        r_reorder[in_rob_commit_rd] <= ZERO_REORDER;
      end
      if (w_flush_valid) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          r_busy[i]    <= 1'b0;
          r_reorder[i] <= ZERO_REORDER;
        end
      end else if (w_rename_valid) begin
        r_busy[in_decoder_rename_rd]    <= 1'b1;
        r_reorder[in_decoder_rename_rd] <= in_decoder_rename_reorder;
      end
    end
  end

  // Both operand ports share the same query function
  always_comb begin
    w_rs_q = f_query(in_decoder_rs);
    w_rt_q = f_query(in_decoder_rt);
  end

  assign out_decoder_rs_busy    = w_rs_q.busy;
  assign out_decoder_rs_reorder = w_rs_q.reorder;
  assign out_decoder_rs_value   = w_rs_q.value;
  assign out_decoder_rt_busy    = w_rt_q.busy;
  assign out_decoder_rt_reorder = w_rt_q.reorder;
  assign out_decoder_rt_value   = w_rt_q.value;

endmodule : regfile_rename

`default_nettype wire

// File: tb/tb_regfile_rename.sv
// ============================================================================
// Module  : tb_regfile_rename
// Brief   : Directed self-checking bench for regfile_rename.
//           Expected query results are queued when stimulus is driven and
//           compared when the query output settles.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_rename;
  import regfile_rename_pkg::*;

  logic                  in_clk = 1'b0;
  logic                  in_rst;
  logic                  in_rdy;
  logic                  in_flush_enable;
  logic                  in_decoder_rename_enable;
  logic [REG_WIDTH-1:0]  in_decoder_rename_rd;
  logic [ROB_WIDTH-1:0]  in_decoder_rename_reorder;
  logic [REG_WIDTH-1:0]  in_decoder_rs;
  logic [REG_WIDTH-1:0]  in_decoder_rt;
  logic                  out_decoder_rs_busy;
  logic                  out_decoder_rt_busy;
  logic [ROB_WIDTH-1:0]  out_decoder_rs_reorder;
  logic [ROB_WIDTH-1:0]  out_decoder_rt_reorder;
  logic [DATA_WIDTH-1:0] out_decoder_rs_value;
  logic [DATA_WIDTH-1:0] out_decoder_rt_value;
  logic                  in_rob_commit_enable;
  logic [REG_WIDTH-1:0]  in_rob_commit_rd;
  logic [DATA_WIDTH-1:0] in_rob_commit_value;
  logic [ROB_WIDTH-1:0]  in_rob_commit_reorder;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string                 name;
    logic                  busy;
    logic [ROB_WIDTH-1:0]  reorder;
    logic [DATA_WIDTH-1:0] value;
  } exp_t;

  exp_t sb[$];

  regfile_rename dut (
    .in_clk                    (in_clk),
    .in_rst                    (in_rst),
    .in_rdy                    (in_rdy),
    .in_flush_enable           (in_flush_enable),
    .in_decoder_rename_enable  (in_decoder_rename_enable),
    .in_decoder_rename_rd      (in_decoder_rename_rd),
    .in_decoder_rename_reorder (in_decoder_rename_reorder),
    .in_decoder_rs             (in_decoder_rs),
    .in_decoder_rt             (in_decoder_rt),
    .out_decoder_rs_busy       (out_decoder_rs_busy),
    .out_decoder_rt_busy       (out_decoder_rt_busy),
    .out_decoder_rs_reorder    (out_decoder_rs_reorder),
    .out_decoder_rt_reorder    (out_decoder_rt_reorder),
    .out_decoder_rs_value      (out_decoder_rs_value),
    .out_decoder_rt_value      (out_decoder_rt_value),
    .in_rob_commit_enable      (in_rob_commit_enable),
    .in_rob_commit_rd          (in_rob_commit_rd),
    .in_rob_commit_value       (in_rob_commit_value),
    .in_rob_commit_reorder     (in_rob_commit_reorder)
  );

  always #5 in_clk = ~in_clk;

  task automatic clear_strobes();
    in_flush_enable          = 1'b0;
    in_decoder_rename_enable = 1'b0;
    in_decoder_rename_rd     = '0;
    in_decoder_rename_reorder = '0;
    in_rob_commit_enable     = 1'b0;
    in_rob_commit_rd         = '0;
    in_rob_commit_value      = '0;
    in_rob_commit_reorder    = '0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge in_clk);
    #1;
    clear_strobes();
  endtask

  task automatic rename(input logic [REG_WIDTH-1:0] rd, input logic [ROB_WIDTH-1:0] tag);
    in_decoder_rename_enable  = 1'b1;
    in_decoder_rename_rd      = rd;
    in_decoder_rename_reorder = tag;
  endtask

  task automatic commit(input logic [REG_WIDTH-1:0] rd, input logic [DATA_WIDTH-1:0] v,
                        input logic [ROB_WIDTH-1:0] tag);
    in_rob_commit_enable  = 1'b1;
    in_rob_commit_rd      = rd;
    in_rob_commit_value   = v;
    in_rob_commit_reorder = tag;
  endtask

  // Push the expectation, drive the query, then pop and compare once settled
  task automatic query(input string name, input bit use_rt, input logic [REG_WIDTH-1:0] r,
                       input logic b, input logic [ROB_WIDTH-1:0] t,
                       input logic [DATA_WIDTH-1:0] v);
    exp_t e;
    logic                  ob;
    logic [ROB_WIDTH-1:0]  ot;
    logic [DATA_WIDTH-1:0] ov;
    sb.push_back('{name: name, busy: b, reorder: t, value: v});
    if (use_rt) in_decoder_rt = r;
    else        in_decoder_rs = r;
    #1;
    ob = use_rt ? out_decoder_rt_busy    : out_decoder_rs_busy;
    ot = use_rt ? out_decoder_rt_reorder : out_decoder_rs_reorder;
    ov = use_rt ? out_decoder_rt_value   : out_decoder_rs_value;
    e = sb.pop_front();
    n_cmp++;
    assert (ob === e.busy) else begin
      n_fail++;
      $error("FAIL %s.busy observed %0h expected %0h", e.name, ob, e.busy);
    end
    n_cmp++;
    assert (ot === e.reorder) else begin
      n_fail++;
      $error("FAIL %s.tag observed %0h expected %0h", e.name, ot, e.reorder);
    end
    n_cmp++;
    assert (ov === e.value) else begin
      n_fail++;
      $error("FAIL %s.value observed %0h expected %0h", e.name, ov, e.value);
    end
  endtask

  initial begin
    in_rst        = 1'b0;
    in_rdy        = 1'b1;
    in_decoder_rs = '0;
    in_decoder_rt = '0;
    clear_strobes();

    // Reset state, observed while reset is held
    #2;
    query("reset_x5", 1'b0, 5'd5, 1'b0, 4'd0, 32'h0);
    query("reset_x31", 1'b1, 5'd31, 1'b0, 4'd0, 32'h0);
    #18;
    in_rst = 1'b1;
    step();

    // Rename then commit with matching tag
    rename(5'd5, 4'd3);
    step();
    query("ren_x5", 1'b0, 5'd5, 1'b1, 4'd3, 32'h0);
    commit(5'd5, 32'hDEAD, 4'd3);
    step();
    query("cmt_x5", 1'b1, 5'd5, 1'b0, 4'd0, 32'hDEAD);

    // Older producer commits after a younger rename
    rename(5'd5, 4'd3);
    step();
    rename(5'd5, 4'd7);
    step();
    commit(5'd5, 32'h11, 4'd3);
    step();
    query("younger_x5", 1'b0, 5'd5, 1'b1, 4'd7, 32'h11);

    // Same-cycle commit and rename on one register: rename wins
    commit(5'd6, 32'h22, 4'd2);
    rename(5'd6, 4'd4);
    step();
    query("same_cyc_x6", 1'b1, 5'd6, 1'b1, 4'd4, 32'h22);

    // Flush with simultaneous commit and a discarded rename
    rename(5'd1, 4'd2);
    step();
    rename(5'd2, 4'd5);
    step();
    in_flush_enable = 1'b1;
    commit(5'd1, 32'h80, 4'd2);
    rename(5'd3, 4'd6);
    step();
    query("flush_x1", 1'b0, 5'd1, 1'b0, 4'd0, 32'h80);
    query("flush_x2", 1'b1, 5'd2, 1'b0, 4'd0, 32'h0);
    query("flush_x3", 1'b0, 5'd3, 1'b0, 4'd0, 32'h0);
    query("flush_x5", 1'b1, 5'd5, 1'b0, 4'd0, 32'h11);
    query("flush_x6", 1'b0, 5'd6, 1'b0, 4'd0, 32'h22);

    // Writes and renames to x0 are dropped
    commit(5'd0, 32'hFFFF, 4'd1);
    rename(5'd0, 4'd1);
    step();
    query("x0_rs", 1'b0, 5'd0, 1'b0, 4'd0, 32'h0);
    query("x0_rt", 1'b1, 5'd0, 1'b0, 4'd0, 32'h0);

    // Stall holds all state
    in_rdy = 1'b0;
    rename(5'd7, 4'd9);
    commit(5'd6, 32'h99, 4'd0);
    step();
    query("stall_x7", 1'b0, 5'd7, 1'b0, 4'd0, 32'h0);
    query("stall_x6", 1'b1, 5'd6, 1'b0, 4'd0, 32'h22);
    in_flush_enable = 1'b1;
    step();
    in_rdy = 1'b1;
    rename(5'd8, 4'd12);
    step();
    in_rdy = 1'b0;
    in_flush_enable = 1'b1;
    step();
    in_rdy = 1'b1;
    query("stall_flush_x8", 1'b0, 5'd8, 1'b1, 4'd12, 32'h0);

    // Commit on the current tag, query in the same cycle
    rename(5'd9, 4'd8);
    step();
    commit(5'd9, 32'h55, 4'd8);
`ifdef REGFILE_BYPASS_EN
    query("bypass_x9", 1'b1, 5'd9, 1'b0, 4'd0, 32'h55);
`else
    query("nobypass_x9", 1'b1, 5'd9, 1'b1, 4'd8, 32'h0);
`endif
    step();
    query("after_x9", 1'b0, 5'd9, 1'b0, 4'd0, 32'h55);

    // Asynchronous reset mid-run clears everything without a clock edge
    #1;
    in_rst = 1'b0;
    #1;
    query("areset_x5", 1'b0, 5'd5, 1'b0, 4'd0, 32'h0);
    query("areset_x8", 1'b1, 5'd8, 1'b0, 4'd0, 32'h0);
    in_rst = 1'b1;
    step();
    query("post_reset_x1", 1'b0, 5'd1, 1'b0, 4'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_regfile_rename

`default_nettype wire
